nat_tuple_extract: RTL and testbench



---
 rtl/nat_tuple_extract_if.sv | 41 ++++
 rtl/nat_tuple_extract.sv | 238 +++++++++++++++++++++++
 tb/tb_nat_tuple_extract.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nat_tuple_extract_if.sv
// -----------------------------------------------------------------------------
// nat_tuple_extract_if
// Groups the byte-stream input, the tuple output handshake and the per-frame
// status pulses of the NAT 5-tuple extractor.
//
// Signals:
//   s_data[7:0]        frame byte, first byte = destination MAC byte 0
//   s_valid            byte valid
//   s_last             final byte of frame, qualified by s_valid
//   s_ready            byte accepted when s_valid && s_ready
//   tuple_data[127:0]  packed 5-tuple
//   tuple_valid        tuple_data holds a tuple
//   tuple_ready        consumer accepts the tuple on tuple_valid && tuple_ready
//   pkt_skip           1-cycle pulse: frame ended and was not eligible
//   pkt_runt           1-cycle pulse: frame ended before the tuple was complete
//
// Modports:
//   slave  - the extractor's view (byte-stream sink, tuple source)
//   master - the environment's view (byte-stream source, tuple sink)
// -----------------------------------------------------------------------------
interface nat_tuple_extract_if;
   logic [7:0]   s_data;
   logic         s_valid;
   logic         s_last;
   logic         s_ready;
   logic [127:0] tuple_data;
   logic         tuple_valid;
   logic         tuple_ready;
   logic         pkt_skip;
   logic         pkt_runt;

   modport slave (
      input  s_data, s_valid, s_last, tuple_ready,
      output s_ready, tuple_data, tuple_valid, pkt_skip, pkt_runt
   );

   modport master (
      output s_data, s_valid, s_last, tuple_ready,
      input  s_ready, tuple_data, tuple_valid, pkt_skip, pkt_runt
   );
endinterface

// File: rtl/nat_tuple_extract.sv
// -----------------------------------------------------------------------------
// nat_tuple_extract
// Parses an Ethernet frame delivered as a byte stream (Ethernet + IPv4 +
// TCP/UDP ports) and emits one packed 128-bit 5-tuple per eligible frame for
// the NAT connection hash stage.
//
// Tuple packing (src in the lower fields, dst in the upper fields):
//   [7:0] protocol, [23:8] L4 src port, [39:24] L4 dst port,
//   [71:40] IPv4 src, [103:72] IPv4 dst, [127:104] zero.
//
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - nat_tuple_extract_if.slave (byte stream in, tuple out, pulses)
//
// Parameters:
//   CNT_W    - width of the saturating in-frame byte counter
//   ETH_IPV4 - EtherType accepted as IPv4
//
// Build option:
//   NAT_VLAN_EN - when defined, one 802.1Q tag (8100) at bytes 12-13 is
//                 stepped over and the real EtherType is read at bytes 16-17;
//                 a second tag makes the frame ineligible. When undefined,
//                 8100 is simply a non-IPv4 EtherType.
// -----------------------------------------------------------------------------
module nat_tuple_extract #(
   parameter int unsigned CNT_W    = 11,
   parameter logic [15:0] ETH_IPV4 = 16'h0800
) (
   input  logic              clk,
   input  logic              rst,
   nat_tuple_extract_if.slave bus
);

   typedef enum logic [1:0] {ST_ETH, ST_IP, ST_L4, ST_DRAIN} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             skip_q;
   logic [127:0]     tuple_data_q;
   logic             tuple_valid_q;
   logic             pkt_skip_q;
   logic             pkt_runt_q;

   // Header capture registers
   logic [7:0]       etype_hi_q;
   logic [3:0]       ihl_q;
   logic             bad_q;       // frame found ineligible inside the IP header
   logic [7:0]       proto_q;
   logic [31:0]      src_ip_q;
   logic [31:0]      dst_ip_q;
   logic [23:0]      l4_q;        // first three L4 port bytes
   logic [1:0]       l4_idx_q;

   logic             s_ready_int;
   logic             byte_acc;
   logic             l4_last;
   logic             tuple_load;
   logic             set_skip;
   logic [15:0]      etype;
   logic [CNT_W-1:0] etype_pos;
   logic [CNT_W-1:0] ip_base;
   logic [CNT_W-1:0] ip_off;
   logic [CNT_W-1:0] ip_end;

`ifdef NAT_VLAN_EN
   localparam logic [15:0] ETH_VLAN = 16'h8100;
   logic vlan_q;
   logic enter_vlan;
   assign etype_pos = vlan_q ? CNT_W'(17) : CNT_W'(13);
   assign ip_base   = vlan_q ? CNT_W'(18) : CNT_W'(14);
`else
   assign etype_pos = CNT_W'(13);
   assign ip_base   = CNT_W'(14);
`endif

   assign etype  = {etype_hi_q, bus.s_data};
   assign ip_off = cnt_q - ip_base;
   assign ip_end = CNT_W'({ihl_q, 2'b00}) - CNT_W'(1);

   // The only stall point: the byte that would load a new tuple while the
   // previous one is still waiting for the consumer.
   assign l4_last     = (state_q == ST_L4) && (l4_idx_q == 2'd3);
   assign s_ready_int = !(l4_last && tuple_valid_q && !bus.tuple_ready);
   assign byte_acc    = bus.s_valid && s_ready_int;
   assign tuple_load  = byte_acc && l4_last;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_ETH;
      else     state_q <= state_d;
   end

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d  = state_q;
      set_skip = 1'b0;
`ifdef NAT_VLAN_EN
      enter_vlan = 1'b0;
`endif
      if (byte_acc) begin
         case (state_q)
            ST_ETH: begin
               if (cnt_q == etype_pos) begin
                  if (etype == ETH_IPV4) begin
                     state_d = ST_IP;
                  end
`ifdef NAT_VLAN_EN
                  else if (etype == ETH_VLAN && !vlan_q) begin
                     enter_vlan = 1'b1;
                  end
`endif
                  else begin
                     state_d  = ST_DRAIN;
                     set_skip = 1'b1;
                  end
               end
            end
            ST_IP: begin
               if (ip_off == '0) begin
                  if (bus.s_data[3:0] < 4'd5) begin
                     state_d  = ST_DRAIN;
                     set_skip = 1'b1;
                  end
               end else if (ip_off == ip_end) begin
                  if (bad_q) begin
                     state_d  = ST_DRAIN;
                     set_skip = 1'b1;
                  end else begin
                     state_d = ST_L4;
                  end
               end
            end
            ST_L4: begin
               if (l4_idx_q == 2'd3) state_d = ST_DRAIN;
            end
            default: ;
         endcase
         // End of frame overrides any decision taken on the same byte.
         if (bus.s_last) state_d = ST_ETH;
      end
   end

   // ------------------------------------------------ control / output regs
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         skip_q        <= 1'b0;
         tuple_data_q  <= '0;
         tuple_valid_q <= 1'b0;
         pkt_skip_q    <= 1'b0;
         pkt_runt_q    <= 1'b0;
`ifdef NAT_VLAN_EN
         vlan_q        <= 1'b0;
`endif
      end else begin
         pkt_skip_q <= 1'b0;
         pkt_runt_q <= 1'b0;

         // A load in the same cycle as a handshake replaces the old tuple.
         if (tuple_load) begin
            tuple_valid_q <= 1'b1;
            tuple_data_q  <= {24'h0, dst_ip_q, src_ip_q,
                              l4_q[7:0], bus.s_data, l4_q[23:8], proto_q};
         end else if (tuple_valid_q && bus.tuple_ready) begin
            tuple_valid_q <= 1'b0;
         end

         if (byte_acc) begin
            if (bus.s_last) begin
               cnt_q  <= '0;
               skip_q <= 1'b0;
`ifdef NAT_VLAN_EN
               vlan_q <= 1'b0;
`endif
               // Frames ending before DRAIN are runts unless this very byte
               // completed the tuple (header-only UDP).
               if (state_q == ST_DRAIN) pkt_skip_q <= skip_q;
               else if (!tuple_load)    pkt_runt_q <= 1'b1;
            end else begin
               if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
               if (set_skip)         skip_q <= 1'b1;
`ifdef NAT_VLAN_EN
               if (enter_vlan)       vlan_q <= 1'b1;
`endif
            end
         end
      end
   end

   // ----------------------------------------------------- header capture
   // NOTE: these registers are left out of reset on purpose: each one is
   // rewritten within the frame before it is used, so a reset adds only fanout.
   always_ff @(posedge clk) begin
      if (byte_acc) begin
         case (state_q)
            ST_ETH: etype_hi_q <= bus.s_data;
            ST_IP: begin
               l4_idx_q <= 2'd0;
               if (ip_off == CNT_W'(0)) begin
                  ihl_q <= bus.s_data[3:0];
                  bad_q <= 1'b0;
               end
               // Flags/fragment offset: MF bit or any offset bit => fragment.
               if (ip_off == CNT_W'(6) && (bus.s_data[5] || bus.s_data[4:0] != 5'd0))
                  bad_q <= 1'b1;
               if (ip_off == CNT_W'(7) && bus.s_data != 8'd0)
                  bad_q <= 1'b1;
               if (ip_off == CNT_W'(9)) begin
                  proto_q <= bus.s_data;
                  if (bus.s_data != 8'd6 && bus.s_data != 8'd17) bad_q <= 1'b1;
               end
               if (ip_off >= CNT_W'(12) && ip_off <= CNT_W'(15))
                  src_ip_q <= {src_ip_q[23:0], bus.s_data};
               if (ip_off >= CNT_W'(16) && ip_off <= CNT_W'(19))
                  dst_ip_q <= {dst_ip_q[23:0], bus.s_data};
            end
            ST_L4: begin
               l4_q     <= {l4_q[15:0], bus.s_data};
               l4_idx_q <= l4_idx_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.s_ready     = s_ready_int;
   assign bus.tuple_data  = tuple_data_q;
   assign bus.tuple_valid = tuple_valid_q;
   assign bus.pkt_skip    = pkt_skip_q;
   assign bus.pkt_runt    = pkt_runt_q;

endmodule

// File: tb/tb_nat_tuple_extract.sv
// -----------------------------------------------------------------------------
// tb_nat_tuple_extract
// Self-checking bench for nat_tuple_extract. Frames are built as byte queues;
// a frame-level reference model classifies each one (tuple / skip / runt) and
// extracts the expected tuple straight from the frame bytes. A per-cycle
// expectation of the tuple output register and pulses is checked every cycle.
// -----------------------------------------------------------------------------
module tb_nat_tuple_extract;

   typedef logic [7:0] byte_q_t[$];

   localparam int K_NONE  = 0;
   localparam int K_TUPLE = 1;
   localparam int K_SKIP  = 2;
   localparam int K_RUNT  = 3;

   logic clk = 1'b0;
   logic rst;

   nat_tuple_extract_if bus ();

   nat_tuple_extract dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int           n_tests = 0;
   int           n_fail  = 0;
   bit           exp_valid;
   logic [127:0] exp_data;
   bit           exp_skip;
   bit           exp_runt;
   bit           just_loaded;
   logic [127:0] last_tuple;
   int           ready_mode;   // 0: always ready, 1: random, 2: hold off
   int           stall_cnt;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------ reference model
   function automatic void model(input byte_q_t f, output int kind,
                                 output logic [127:0] tup, output int load_idx);
      int          n;
      int          base;
      int          hdr;
      logic [15:0] et;
      logic [7:0]  b0, b6, b7, pr;
      n        = f.size();
      base     = 14;
      tup      = '0;
      load_idx = -1;
      kind     = K_RUNT;
      if (n <= 14) return;
      et = {f[12], f[13]};
`ifdef NAT_VLAN_EN
      if (et == 16'h8100) begin
         base = 18;
         if (n <= 18) return;
         et = {f[16], f[17]};
      end
`endif
      if (et != 16'h0800) begin kind = K_SKIP; return; end
      b0 = f[base];
      if (b0[3:0] < 4'd5) begin
         kind = (n == base + 1) ? K_RUNT : K_SKIP;
         return;
      end
      hdr = 4 * int'(b0[3:0]);
      if (n <= base + hdr) return;
      b6 = f[base+6];
      b7 = f[base+7];
      pr = f[base+9];
      if (b6[5] || {b6[4:0], b7} != 13'd0 || (pr != 8'd6 && pr != 8'd17)) begin
         kind = K_SKIP;
         return;
      end
      if (n < base + hdr + 4) return;
      kind     = K_TUPLE;
      load_idx = base + hdr + 3;
      tup = {24'h0,
             f[base+16], f[base+17], f[base+18], f[base+19],
             f[base+12], f[base+13], f[base+14], f[base+15],
             f[base+hdr+2], f[base+hdr+3],
             f[base+hdr], f[base+hdr+1],
             pr};
   endfunction

   function automatic void build_frame(output byte_q_t f, input bit vlan, input logic [15:0] etype,
                                       input logic [3:0] ihl, input logic [15:0] frag,
                                       input logic [7:0] proto, input logic [31:0] sip,
                                       input logic [31:0] dip, input logic [15:0] sp,
                                       input logic [15:0] dp, input int pay, input int trunc);
      int nopt;
      f = {};
      for (int i = 0; i < 12; i++) f.push_back(8'($urandom));
      if (vlan) begin
         f.push_back(8'h81); f.push_back(8'h00);
         f.push_back(8'($urandom_range(15))); f.push_back(8'($urandom));
      end
      f.push_back(etype[15:8]); f.push_back(etype[7:0]);
      f.push_back({4'h4, ihl}); f.push_back(8'h00);
      f.push_back(8'h00); f.push_back(8'h40);
      f.push_back(8'($urandom)); f.push_back(8'($urandom));
      f.push_back(frag[15:8]); f.push_back(frag[7:0]);
      f.push_back(8'h40); f.push_back(proto);
      f.push_back(8'($urandom)); f.push_back(8'($urandom));
      for (int i = 3; i >= 0; i--) f.push_back(sip[8*i +: 8]);
      for (int i = 3; i >= 0; i--) f.push_back(dip[8*i +: 8]);
      nopt = (ihl > 4'd5) ? 4 * (int'(ihl) - 5) : 0;
      for (int i = 0; i < nopt; i++) f.push_back(8'($urandom));
      f.push_back(sp[15:8]); f.push_back(sp[7:0]);
      f.push_back(dp[15:8]); f.push_back(dp[7:0]);
      for (int i = 0; i < pay; i++) f.push_back(8'($urandom));
      if (trunc > 0) while (f.size() > trunc) void'(f.pop_back());
   endfunction

   // ------------------------------------------------------ cycle driver
   // Entered and left just after a rising edge; checks at the falling edge.
   task automatic clk_cycle(input bit v, input logic [7:0] d, input bit l, input bit at_load,
                            input int kind, input logic [127:0] tup, output bit acc);
      bit exp_rdy;
      bit hs;
      bus.s_valid = v;
      bus.s_data  = d;
      bus.s_last  = l;
      case (ready_mode)
         0: bus.tuple_ready = 1'b1;
         1: bus.tuple_ready = 1'($urandom_range(1));
         default: begin
            if (at_load && exp_valid) begin
               if (stall_cnt >= 6) bus.tuple_ready = 1'b1;
               else begin bus.tuple_ready = 1'b0; stall_cnt++; end
            end else begin
               bus.tuple_ready = 1'b0;
            end
         end
      endcase
      @(negedge clk);
      exp_rdy = !(at_load && exp_valid && !bus.tuple_ready);
      check("s_ready", 128'(bus.s_ready), 128'(exp_rdy));
      check("tuple_valid", 128'(bus.tuple_valid), 128'(exp_valid));
      if (exp_valid) check("tuple_data", bus.tuple_data, exp_data);
      check("pkt_skip", 128'(bus.pkt_skip), 128'(exp_skip));
      check("pkt_runt", 128'(bus.pkt_runt), 128'(exp_runt));
      if (just_loaded) begin
         last_tuple  = bus.tuple_data;
         just_loaded = 1'b0;
      end
      acc      = v && exp_rdy;
      hs       = exp_valid && bus.tuple_ready;
      exp_skip = acc && l && (kind == K_SKIP);
      exp_runt = acc && l && (kind == K_RUNT);
      if (acc && at_load) begin
         exp_valid   = 1'b1;
         exp_data    = tup;
         just_loaded = 1'b1;
         stall_cnt   = 0;
      end else if (hs) begin
         exp_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) clk_cycle(1'b0, 8'h00, 1'b0, 1'b0, K_NONE, '0, acc);
   endtask

   task automatic run_frame(input byte_q_t f, input int bubble_pct);
      int           kind;
      int           load_idx;
      logic [127:0] tup;
      int           i;
      bit           acc;
      model(f, kind, tup, load_idx);
      i = 0;
      while (i < f.size()) begin
         if ($urandom_range(99) < bubble_pct)
            clk_cycle(1'b0, 8'h00, 1'b0, (i == load_idx), kind, tup, acc);
         else
            clk_cycle(1'b1, f[i], (i == f.size() - 1), (i == load_idx), kind, tup, acc);
         if (acc) i++;
      end
   endtask

   // Sends the first k bytes of f (never its last byte), without s_last.
   task automatic run_prefix(input byte_q_t f, input int k);
      int           kind;
      int           load_idx;
      logic [127:0] tup;
      int           i;
      bit           acc;
      model(f, kind, tup, load_idx);
      i = 0;
      while (i < k) begin
         clk_cycle(1'b1, f[i], 1'b0, (i == load_idx), kind, tup, acc);
         if (acc) i++;
      end
   endtask

   task automatic do_reset();
      bus.s_valid     = 1'b0;
      bus.s_last      = 1'b0;
      bus.s_data      = 8'h00;
      bus.tuple_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst         = 1'b0;
      exp_valid   = 1'b0;
      exp_data    = '0;
      exp_skip    = 1'b0;
      exp_runt    = 1'b0;
      just_loaded = 1'b0;
      stall_cnt   = 0;
      @(negedge clk);
      check("rst_tuple_valid", 128'(bus.tuple_valid), 128'(0));
      check("rst_tuple_data", bus.tuple_data, 128'(0));
      check("rst_pkt_skip", 128'(bus.pkt_skip), 128'(0));
      check("rst_pkt_runt", 128'(bus.pkt_runt), 128'(0));
      check("rst_s_ready", 128'(bus.s_ready), 128'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t      f;
      byte_q_t      tail;
      logic [127:0] udp_vec;
      int           r, k;
      bit           vlan;
      logic [15:0]  et;
      logic [3:0]   ihl;
      logic [15:0]  frag;
      logic [7:0]   proto;

      udp_vec    = 128'h0000000000_08080808_0A000001_0035_04D2_11;
      ready_mode = 0;
      do_reset();

      // UDP 10.0.0.1:1234 -> 8.8.8.8:53
      build_frame(f, 0, 16'h0800, 4'd5, 16'h4000, 8'd17, 32'h0A000001, 32'h08080808,
                  16'd1234, 16'd53, 8, 0);
      run_frame(f, 0);
      idle(2);
      check("udp_vector", last_tuple, udp_vec);

      // TCP, IHL=6, ports 80 -> 443
      build_frame(f, 0, 16'h0800, 4'd6, 16'h0000, 8'd6, 32'hC0A80001, 32'h01020304,
                  16'd80, 16'd443, 10, 0);
      run_frame(f, 0);
      idle(2);
      check("tcp_ports", 128'(last_tuple[39:8]), 128'(32'h01BB0050));
      check("tcp_proto", 128'(last_tuple[7:0]), 128'(8'h06));

      // ARP, 60 bytes: skip pulse only
      build_frame(f, 0, 16'h0806, 4'd5, 16'h0000, 8'd17, 32'h0, 32'h0, 16'd0, 16'd0, 60, 60);
      while (f.size() < 60) f.push_back(8'h00);
      run_frame(f, 0);
      idle(2);

      // 20-byte runt ending inside the IP header, then a good UDP frame
      build_frame(f, 0, 16'h0800, 4'd5, 16'h0000, 8'd17, 32'h0A000001, 32'h08080808,
                  16'd1234, 16'd53, 0, 20);
      run_frame(f, 0);
      build_frame(f, 0, 16'h0800, 4'd5, 16'h0000, 8'd17, 32'h0A000001, 32'h08080808,
                  16'd1234, 16'd53, 4, 0);
      run_frame(f, 0);
      idle(2);
      check("after_runt", last_tuple, udp_vec);

      // Header-only UDP: 4th L4 byte carries s_last
      build_frame(f, 0, 16'h0800, 4'd5, 16'h0000, 8'd17, 32'h0A0A0A0A, 32'h0B0B0B0B,
                  16'd7, 16'd9, 0, 0);
      run_frame(f, 0);
      idle(2);

      // Two back-to-back UDP frames with the consumer holding off
      ready_mode = 2;
      build_frame(f, 0, 16'h0800, 4'd5, 16'h0000, 8'd17, 32'h01010101, 32'h02020202,
                  16'd100, 16'd200, 3, 0);
      run_frame(f, 0);
      build_frame(f, 0, 16'h0800, 4'd5, 16'h0000, 8'd17, 32'h03030303, 32'h04040404,
                  16'd300, 16'd400, 3, 0);
      run_frame(f, 0);
      idle(3);
      ready_mode = 0;
      idle(2);

      // Fragment: MF set
      build_frame(f, 0, 16'h0800, 4'd5, 16'h2000, 8'd17, 32'h0A000001, 32'h08080808,
                  16'd1234, 16'd53, 8, 0);
      run_frame(f, 0);
      idle(2);

      // VLAN-tagged UDP (tuple when the tag option is built in, skip otherwise)
      build_frame(f, 1, 16'h0800, 4'd5, 16'h4000, 8'd17, 32'h0A000001, 32'h08080808,
                  16'd1234, 16'd53, 8, 0);
      run_frame(f, 0);
      idle(2);
`ifdef NAT_VLAN_EN
      check("vlan_vector", last_tuple, udp_vec);
`endif

      // Randomized frames
      for (int t = 0; t < 160; t++) begin
         r     = $urandom_range(99);
         vlan  = (r < 10);
         et    = (r >= 10 && r < 20) ? 16'h0806 : ((r >= 95) ? 16'h86DD : 16'h0800);
         ihl   = ($urandom_range(9) == 0) ? 4'($urandom_range(4)) : 4'($urandom_range(8, 5));
         frag  = ($urandom_range(7) == 0) ? 16'($urandom) & 16'h3FFF : 16'h4000;
         r     = $urandom_range(9);
         proto = (r < 4) ? 8'd6 : ((r < 8) ? 8'd17 : 8'd1);
         build_frame(f, vlan, et, ihl, frag, proto, $urandom, $urandom,
                     16'($urandom), 16'($urandom), $urandom_range(24),
                     ($urandom_range(7) == 0) ? $urandom_range(80, 1) : 0);
         ready_mode = $urandom_range(1);
         if ($urandom_range(24) == 0 && f.size() > 2) begin
            // Reset mid-frame: the remaining bytes form a new frame.
            k = $urandom_range(f.size() - 1, 1);
            run_prefix(f, k);
            do_reset();
            tail = f[k:$];
            run_frame(tail, 20);
         end else begin
            run_frame(f, 20);
         end
         if ($urandom_range(3) == 0) idle($urandom_range(3));
      end

      ready_mode = 0;
      idle(5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
